spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 14 +
 rtl/spi_rx_fifo.sv | 70 +++++++
 rtl/spi_slave.sv | 205 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, byte width and
// the byte shifted out when the master clocks a byte we have nothing for.
package spi_slave_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] UNDERRUN_FILL = 8'hFF;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive byte FIFO for the SPI slave.
// Ports:
//   HCLK, HRESETn      system clock, async active-low reset
//   push_i, push_data_i write request and byte
//   pop_i              remove head (ignored when empty)
//   data_o             head byte, 0 when empty
//   level_o            occupancy 0..DEPTH
//   full_o, empty_o    status
// A push while full is accepted only if a pop happens in the same cycle.
module spi_rx_fifo
   import spi_slave_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic                         push_i,
   input  logic [BYTE_W-1:0]            push_data_i,
   input  logic                         pop_i,
   output logic [BYTE_W-1:0]            data_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_ff @(posedge HCLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (do_push && !do_pop) begin
            level_q <= level_q + LW'(1);
         end else if (!do_push && do_pop) begin
            level_q <= level_q - LW'(1);
         end
      end
   end

endmodule

// File: rtl/spi_slave.sv
// SPI slave, CPHA 0, oversampled in the HCLK domain.
// Ports:
//   HCLK, HRESETn                  system clock, async active-low reset
//   SPI_CLK_i, SPI_SS_i, SPI_MOSI_i  SPI pins from the master (async)
//   SPI_MISO_o                     serial data out, MSB first
//   tx_data_i/tx_valid_i/tx_ready_o  one-byte TX holding register
//   rx_data_o/rx_valid_o/rx_ready_i  RX FIFO head
//   rx_level_o                     RX FIFO occupancy
//   overrun_o, underrun_o          sticky error flags, cleared by clear_i
//   frame_abort_o                  one-cycle pulse on SS release mid-byte
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | SS high; MISO driven 0, waiting for SS falling edge
// ST_ACTIVE | SS low; sampling on leading, shifting on trailing edge
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter bit CPOL     = 1'b0,
   parameter int RX_DEPTH = 4
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              SPI_CLK_i,
   input  logic              SPI_SS_i,
   input  logic              SPI_MOSI_i,
   output logic              SPI_MISO_o,
   input  logic [BYTE_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [BYTE_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic [2:0]        rx_level_o,
   output logic              overrun_o,
   output logic              underrun_o,
   output logic              frame_abort_o,
   input  logic              clear_i
);

   logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic ss_s1_q, ss_s2_q, ss_s3_q;
   logic mosi_s1_q, mosi_s2_q;
   logic [2:0] settle_q;
   logic       ss_arm_q;

   spi_state_e        state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   // Only seven bits are held: the eighth arrives on the push cycle itself.
   logic [6:0]        rx_shift_q, rx_shift_d;
   logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
   logic [BYTE_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              overrun_q, overrun_d;
   logic              underrun_q, underrun_d;
   logic              abort_q, abort_d;

   logic lead, trail, ss_fall, ss_rise;
   logic consume, under_set, over_set, push, pop;
   logic fifo_full, fifo_empty;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sclk_s1_q <= CPOL;
         sclk_s2_q <= CPOL;
         sclk_s3_q <= CPOL;
         ss_s1_q   <= 1'b1;
         ss_s2_q   <= 1'b1;
         ss_s3_q   <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
         settle_q  <= '0;
         ss_arm_q  <= 1'b0;
      end else begin
         sclk_s1_q <= SPI_CLK_i;
         sclk_s2_q <= sclk_s1_q;
         sclk_s3_q <= sclk_s2_q;
         ss_s1_q   <= SPI_SS_i;
         ss_s2_q   <= ss_s1_q;
         ss_s3_q   <= ss_s2_q;
         mosi_s1_q <= SPI_MOSI_i;
         mosi_s2_q <= mosi_s1_q;
         settle_q  <= {settle_q[1:0], 1'b1};
         // The SS synchronizer resets to "high"; only a high level actually
         // seen on the pin after reset arms falling-edge detection, so a
         // frame interrupted by reset is never resumed mid-byte.
         ss_arm_q  <= ss_arm_q | (settle_q[2] & ss_s3_q);
      end
   end

   assign lead    = (sclk_s2_q != CPOL) && (sclk_s3_q == CPOL);
   assign trail   = (sclk_s2_q == CPOL) && (sclk_s3_q != CPOL);
   assign ss_fall = ss_arm_q && ss_s3_q && !ss_s2_q;
   assign ss_rise = ss_s2_q && !ss_s3_q;

   assign rx_valid_o = !fifo_empty;
   assign pop        = rx_valid_o && rx_ready_i;
   assign over_set   = push && fifo_full && !pop;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      abort_d     = 1'b0;
      push        = 1'b0;
      consume     = 1'b0;
      under_set   = 1'b0;

      if (tx_valid_i && !hold_full_q) begin
         hold_d      = tx_data_i;
         hold_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = '0;
               consume   = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (ss_rise) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
               abort_d   = (bit_cnt_q != 3'd0);
            end else if (lead) begin
               rx_shift_d = {rx_shift_q[5:0], mosi_s2_q};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               push       = (bit_cnt_q == 3'd7);
            end else if (trail) begin
               if (bit_cnt_q == 3'd0) begin
                  consume = 1'b1;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A consume only ever sees a full holding register when no load is
      // in flight, so clearing hold_full here cannot lose a new byte.
      if (consume) begin
         if (hold_full_q) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
         end else begin
            tx_shift_d = UNDERRUN_FILL;
            under_set  = 1'b1;
         end
      end
   end

   assign overrun_d  = (overrun_q & ~clear_i) | over_set;
   assign underrun_d = (underrun_q & ~clear_i) | under_set;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         overrun_q   <= overrun_d;
         underrun_q  <= underrun_d;
         abort_q     <= abort_d;
      end
   end

   assign SPI_MISO_o    = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b0;
   assign tx_ready_o    = !hold_full_q;
   assign overrun_o     = overrun_q;
   assign underrun_o    = underrun_q;
   assign frame_abort_o = abort_q;

   spi_rx_fifo #(
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .push_i      (push),
      .push_data_i ({rx_shift_q, mosi_s2_q}),
      .pop_i       (pop),
      .data_o      (rx_data_o),
      .level_o     (rx_level_o),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

   localparam int HALF = 80;

   logic HCLK = 1'b0;
   logic HRESETn;
   always #5 HCLK = ~HCLK;

   logic       sel, sck_act, ss, mosi, tx_valid, rx_ready, clear;
   logic [7:0] tx_data;

   logic       sclk0, ss0, txv0, rxr0, sclk1, ss1, txv1, rxr1;
   logic       miso0, txr0, rxv0, ov0, un0, ab0;
   logic       miso1, txr1, rxv1, ov1, un1, ab1;
   logic [7:0] rxd0, rxd1;
   logic [2:0] lvl0, lvl1;

   assign sclk0 = sel ? 1'b0 : sck_act;
   assign sclk1 = sel ? ~sck_act : 1'b1;
   assign ss0   = sel ? 1'b1 : ss;
   assign ss1   = sel ? ss : 1'b1;
   assign txv0  = tx_valid & ~sel;
   assign txv1  = tx_valid & sel;
   assign rxr0  = rx_ready & ~sel;
   assign rxr1  = rx_ready & sel;

   logic       mon_miso, mon_txr, mon_rxv, mon_ov, mon_un, mon_ab;
   logic [7:0] mon_rxd;
   logic [2:0] mon_lvl;
   assign mon_miso = sel ? miso1 : miso0;
   assign mon_txr  = sel ? txr1  : txr0;
   assign mon_rxv  = sel ? rxv1  : rxv0;
   assign mon_ov   = sel ? ov1   : ov0;
   assign mon_un   = sel ? un1   : un0;
   assign mon_ab   = sel ? ab1   : ab0;
   assign mon_rxd  = sel ? rxd1  : rxd0;
   assign mon_lvl  = sel ? lvl1  : lvl0;

   spi_slave #(.CPOL(1'b0), .RX_DEPTH(4)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .SPI_CLK_i(sclk0), .SPI_SS_i(ss0), .SPI_MOSI_i(mosi), .SPI_MISO_o(miso0),
      .tx_data_i(tx_data), .tx_valid_i(txv0), .tx_ready_o(txr0),
      .rx_data_o(rxd0), .rx_valid_o(rxv0), .rx_ready_i(rxr0), .rx_level_o(lvl0),
      .overrun_o(ov0), .underrun_o(un0), .frame_abort_o(ab0), .clear_i(clear)
   );

   spi_slave #(.CPOL(1'b1), .RX_DEPTH(4)) dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .SPI_CLK_i(sclk1), .SPI_SS_i(ss1), .SPI_MOSI_i(mosi), .SPI_MISO_o(miso1),
      .tx_data_i(tx_data), .tx_valid_i(txv1), .tx_ready_o(txr1),
      .rx_data_o(rxd1), .rx_valid_o(rxv1), .rx_ready_i(rxr1), .rx_level_o(lvl1),
      .overrun_o(ov1), .underrun_o(un1), .frame_abort_o(ab1), .clear_i(clear)
   );

   // Reference model: holding register, sticky flags, expected RX bytes.
   logic [7:0] exp_rx[$];
   bit         m_hold_v, m_over, m_under;
   logic [7:0] m_hold;
   int         exp_abort, seen_abort;
   logic       abort_prev;
   int         checks, errors;

   logic [7:0] fr_mosi[8];
   bit         fr_ld_en[9];
   logic [7:0] fr_ld[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every RX pop is compared with the oldest expected byte.
   always begin
      @(negedge HCLK);
      #1;
      if (HRESETn && mon_rxv && rx_ready) begin
         if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %0h expected none", mon_rxd);
         end else begin
            chk("rx_data", {24'd0, mon_rxd}, {24'd0, exp_rx.pop_front()});
         end
      end
      if (mon_ab) begin
         seen_abort++;
         chk("abort_width", {31'd0, abort_prev}, 32'd0);
      end
      abort_prev = mon_ab;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   function automatic logic [7:0] take_tx();
      if (m_hold_v) begin
         m_hold_v = 1'b0;
         return m_hold;
      end
      m_under = 1'b1;
      return 8'hFF;
   endfunction

   function automatic void model_push(input logic [7:0] b);
      if (exp_rx.size() >= 4) m_over = 1'b1;
      else exp_rx.push_back(b);
   endfunction

   task automatic load_tx(input logic [7:0] b);
      chk("tx_ready_at_load", {31'd0, mon_txr}, {31'd0, !m_hold_v});
      if (!m_hold_v) begin
         tx_data  = b;
         tx_valid = 1'b1;
         #10;
         tx_valid = 1'b0;
         m_hold   = b;
         m_hold_v = 1'b1;
      end else begin
         #10;
      end
   endtask

   task automatic clr_frame(input bit rnd);
      for (int i = 0; i < 9; i++) begin
         fr_ld_en[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         fr_ld[i]    = 8'($urandom);
         if (i < 8) fr_mosi[i] = 8'($urandom);
      end
   endtask

   // Master: CPHA 0, samples MISO on each leading edge; byte k+1 is loaded
   // into the holding register midway through byte k.
   task automatic spi_frame(input int nb, input int last_bits, input bit raise_ss);
      logic [7:0] expm, got;
      int bits;
      if (fr_ld_en[0]) load_tx(fr_ld[0]);
      ss   = 1'b0;
      expm = take_tx();
      for (int k = 0; k < nb; k++) begin
         bits = (k == nb - 1 && last_bits != 0) ? last_bits : 8;
         got  = 8'h00;
         for (int i = 0; i < bits; i++) begin
            mosi = fr_mosi[k][7-i];
            #HALF;
            sck_act    = 1'b1;
            got[7-i]   = mon_miso;
            if (i == 7) model_push(fr_mosi[k]);
            if (i == 3) begin
               if (fr_ld_en[k+1]) load_tx(fr_ld[k+1]);
               else #10;
               #(HALF - 10);
            end else begin
               #HALF;
            end
            sck_act = 1'b0;
         end
         if (bits == 8) begin
            chk("miso_byte", {24'd0, got}, {24'd0, expm});
            expm = take_tx();
         end
      end
      if (raise_ss) begin
         #HALF;
         ss = 1'b1;
         if (last_bits != 0) exp_abort++;
         #200;
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_level"}, {29'd0, mon_lvl}, exp_rx.size());
      chk({tag, "_overrun"}, {31'd0, mon_ov}, {31'd0, m_over});
      chk({tag, "_underrun"}, {31'd0, mon_un}, {31'd0, m_under});
      chk({tag, "_tx_ready"}, {31'd0, mon_txr}, {31'd0, !m_hold_v});
      chk({tag, "_aborts"}, seen_abort, exp_abort);
      if (exp_rx.size() > 0) chk({tag, "_head"}, {24'd0, mon_rxd}, {24'd0, exp_rx[0]});
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_miso"}, {31'd0, mon_miso}, 32'd0);
      chk({tag, "_tx_ready"}, {31'd0, mon_txr}, 32'd1);
      chk({tag, "_rx_valid"}, {31'd0, mon_rxv}, 32'd0);
      chk({tag, "_level"}, {29'd0, mon_lvl}, 32'd0);
      chk({tag, "_rx_data"}, {24'd0, mon_rxd}, 32'd0);
      chk({tag, "_overrun"}, {31'd0, mon_ov}, 32'd0);
      chk({tag, "_underrun"}, {31'd0, mon_un}, 32'd0);
      chk({tag, "_abort"}, {31'd0, mon_ab}, 32'd0);
   endtask

   task automatic clear_flags();
      clear = 1'b1;
      #10;
      clear   = 1'b0;
      m_over  = 1'b0;
      m_under = 1'b0;
      #20;
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      #100;
      rx_ready = 1'b0;
      #20;
   endtask

   initial begin
      HRESETn = 1'b0; sel = 1'b0; sck_act = 1'b0; ss = 1'b1; mosi = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; clear = 1'b0;
      checks = 0; errors = 0; exp_abort = 0; seen_abort = 0; abort_prev = 1'b0;
      m_hold_v = 1'b0; m_hold = 8'h00; m_over = 1'b0; m_under = 1'b0;
      clr_frame(1'b0);
      #23;
      @(negedge HCLK);
      check_reset_vals("por");
      HRESETn = 1'b1;
      #100;

      // Preloaded byte out, 0x3C in.
      clr_frame(1'b0);
      fr_mosi[0] = 8'h3C; fr_ld_en[0] = 1'b1; fr_ld[0] = 8'hA5;
      spi_frame(1, 0, 1'b1);
      check_status("basic");
      drain();
      clear_flags();

      // No preload: 0xFF shifted, underrun.
      clr_frame(1'b0);
      fr_mosi[0] = 8'hC3;
      spi_frame(1, 0, 1'b1);
      check_status("underrun");
      clear_flags();
      check_status("underrun_clr");
      drain();

      // Five bytes, consumer stalled.
      clr_frame(1'b0);
      for (int i = 0; i < 6; i++) fr_ld_en[i] = 1'b1;
      spi_frame(5, 0, 1'b1);
      check_status("overrun");
      clear_flags();
      check_status("overrun_clr");
      drain();
      check_status("overrun_drain");

      // SS released after five bits, then a clean 0x5A.
      clr_frame(1'b0);
      fr_ld_en[0] = 1'b1; fr_ld_en[1] = 1'b1;
      spi_frame(1, 5, 1'b1);
      check_status("abort");
      clr_frame(1'b0);
      fr_mosi[0] = 8'h5A; fr_ld_en[0] = 1'b1;
      spi_frame(1, 0, 1'b1);
      check_status("after_abort");
      drain();
      clear_flags();

      // Randomized frames.
      for (int r = 0; r < 12; r++) begin
         clr_frame(1'b1);
         rx_ready = 1'($urandom_range(0, 1));
         spi_frame($urandom_range(1, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, 1'b1);
         check_status("random");
         if ($urandom_range(0, 1) == 1) clear_flags();
      end
      drain();
      check_status("random_end");

      // Reset mid-byte with two bytes buffered.
      clear_flags();
      clr_frame(1'b0);
      fr_ld_en[0] = 1'b1;
      spi_frame(2, 0, 1'b1);
      check_status("pre_reset");
      clr_frame(1'b0);
      spi_frame(1, 4, 1'b0);
      HRESETn = 1'b0; ss = 1'b1; sck_act = 1'b0;
      #30;
      check_reset_vals("mid_reset");
      exp_rx.delete();
      m_hold_v = 1'b0; m_over = 1'b0; m_under = 1'b0;
      HRESETn = 1'b1;
      #100;
      clr_frame(1'b0);
      fr_mosi[0] = 8'h77; fr_ld_en[0] = 1'b1; fr_ld[0] = 8'h96;
      spi_frame(1, 0, 1'b1);
      check_status("post_reset");
      drain();

      // CPOL=1 instance: four bytes, holding refilled every byte.
      sel = 1'b1;
      m_hold_v = 1'b0; m_over = 1'b0; m_under = 1'b0;
      #100;
      clr_frame(1'b0);
      for (int i = 0; i < 5; i++) begin
         fr_ld_en[i] = 1'b1;
         fr_ld[i]    = 8'h10 + 8'(i);
         if (i < 4) fr_mosi[i] = 8'h01 + 8'(i);
      end
      spi_frame(4, 0, 1'b1);
      check_status("cpol1");
      drain();
      check_status("cpol1_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
